stage_sequencer: RTL
====================

# stage_sequencer

Top-level game-flow FSM that drives the level controller through a full Gold Miner session. It handles the title screen, per-level play, pass/fail/win banners and level advancement. It owns the level controller's `enable` and `cycleLevel` inputs and consumes its `stagePassed`, `stageFailed` and `lastLevelEnded` outputs. It also tells the screen mux which screen to draw.

## Interface
- NUM_LEVELS, 3, number of levels in a session (≥1)
- LEVEL_W, 4, width of levelIndex; 2^LEVEL_W ≥ NUM_LEVELS
- BANNER_SECS, 3, banner display duration in oneSecPulse ticks (≥1)

- clk  in  1  system clock
- resetN  in  1  reset: synchronous, active-high (asserted = 1)
- startKey  in  1  start button level; rising edge detected internally
- oneSecPulse  in  1  one-clk pulse per second
- stagePassed  in  1  level controller: quota met
- stageFailed  in  1  level controller: timer expired below quota
- lastLevelEnded  in  1  level controller: no further level data
- levelEnable  out  1  to level controller `enable`; high only in PLAY
- cycleLevel  out  1  one-clk pulse to level controller: advance to next level
- levelIndex  out  LEVEL_W  current level, 0-based
- screenSel  out  3  0 title, 1 play, 2 pass banner, 3 fail banner, 4 win banner
- gameOver  out  1  high in FAIL
- gameWon  out  1  high in WIN

## Operation
- States: TITLE, ARM, PLAY, PASS, FAIL, WIN.
- Start-edge detector: startEdge = startKey & ~startKey_d.
  - startKey_d resets to 1, so a key held through reset must be released before it can start a game.
- TITLE: on startEdge, levelIndex←0 and go to ARM. All other inputs are ignored.
- ARM: always lasts exactly one cycle, then go to PLAY.
  - levelEnable is 0 in ARM. This guarantees the level controller sees a rising edge of enable and reloads its level data.
- PLAY: levelEnable=1. Priority order:
  1. stageFailed → FAIL.
  2. stagePassed and (levelIndex==NUM_LEVELS-1 or lastLevelEnded) → WIN.
  3. stagePassed → PASS.
  - startKey is ignored.
- Banner states (PASS, FAIL, WIN):
  - bannerCnt←BANNER_SECS on entry.
  - Each oneSecPulse decrements bannerCnt.
  - Exit happens on the cycle where oneSecPulse=1 and bannerCnt==1, i.e. after exactly BANNER_SECS pulses counted from the cycle after entry.
- PASS exit: levelIndex←levelIndex+1, cycleLevel←1 for one cycle, go to ARM.
- FAIL exit and WIN exit: go to TITLE. levelIndex holds its value until the next startEdge.
- levelIndex never exceeds NUM_LEVELS-1. No wrap-around is possible: the last level always exits through WIN.
- stagePassed/stageFailed/lastLevelEnded outside PLAY are ignored.

## Timing
- Reset values: state=TITLE, levelEnable=0, cycleLevel=0, levelIndex=0, screenSel=0, gameOver=0, gameWon=0, bannerCnt=0, startKey_d=1.
- Reset mid-operation returns to TITLE on the next edge from any state. Any pending cycleLevel is dropped.
- levelEnable, screenSel, gameOver and gameWon are decoded from the state register only. There is no input-to-output combinational path.
- cycleLevel and levelIndex are registered and updated on the same edge as the PASS→ARM transition. Both are visible during the ARM cycle.
- Latency:
  - startEdge sampled at edge t → ARM after t, PLAY after t+1. levelEnable is first high in the cycle after edge t+1.
  - stagePassed/stageFailed sampled at edge t → banner state after t. levelEnable drops in the same cycle.
- Simultaneous stagePassed and stageFailed in PLAY → FAIL.
- oneSecPulse coincident with the entry edge into a banner is not counted.

## Test plan
- Reset with startKey held at 1, then release and press → no transition until release. After the press, the ARM cycle shows levelEnable=0 and screenSel=1, followed by PLAY with levelEnable=1 and levelIndex=0.
- PLAY level 0, pulse stagePassed → PASS with screenSel=2. After 3 oneSecPulses, the ARM cycle shows cycleLevel=1 and levelIndex=1, then PLAY.
- Level 2 (NUM_LEVELS=3) with stagePassed → WIN with gameWon=1 and screenSel=4. After 3 pulses → TITLE with levelIndex=2. The next startEdge sets levelIndex=0.
- stagePassed and stageFailed asserted in the same cycle at level 1 → FAIL with gameOver=1 and screenSel=3, no cycleLevel pulse. After 3 pulses → TITLE.
- Level 0 with lastLevelEnded=1 and stagePassed → WIN, not PASS.
- Assert resetN during PASS with bannerCnt=2 → next cycle TITLE with all outputs at their reset values. The following oneSecPulses cause no transition.

Source files
------------

// File: rtl/stage_sequencer.sv
// stage_sequencer: game-flow FSM for a Gold Miner session.
// Walks title -> arm -> play -> pass/fail/win banners, owns the level
// controller's enable/cycleLevel handshake and selects the screen to draw.
module stage_sequencer #(
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned LEVEL_W     = 4,
    parameter int unsigned BANNER_SECS = 3
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startKey,
    input  logic               oneSecPulse,
    input  logic               stagePassed,
    input  logic               stageFailed,
    input  logic               lastLevelEnded,
    output logic               levelEnable,
    output logic               cycleLevel,
    output logic [LEVEL_W-1:0] levelIndex,
    output logic [2:0]         screenSel,
    output logic               gameOver,
    output logic               gameWon
);

    localparam int unsigned CNT_W = $clog2(BANNER_SECS + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0]   BANNER_LOAD = CNT_W'(BANNER_SECS);

    localparam logic [2:0] SCR_TITLE = 3'd0;
    localparam logic [2:0] SCR_PLAY  = 3'd1;
    localparam logic [2:0] SCR_PASS  = 3'd2;
    localparam logic [2:0] SCR_FAIL  = 3'd3;
    localparam logic [2:0] SCR_WIN   = 3'd4;

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   banner_cnt;
    logic [CNT_W-1:0]   banner_next;
    logic [LEVEL_W-1:0] level_next;
    logic               cycle_next;
    logic               start_d;
    logic               start_edge;
    logic               enable_next;
    logic [2:0]         screen_next;
    logic               over_next;
    logic               won_next;

    // Start key is a level; only a fresh press may start a game.
    assign start_edge = startKey & ~start_d;

    // Next-state, banner countdown and level bookkeeping.
    always_comb begin
        state_next  = state;
        banner_next = banner_cnt;
        level_next  = levelIndex;
        cycle_next  = 1'b0;
        case (state)
            S_TITLE: begin
                if (start_edge) begin
                    level_next = '0;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                // One idle cycle so the level controller sees enable rise.
                state_next = S_PLAY;
            end
            S_PLAY: begin
                if (stageFailed) begin
                    state_next  = S_FAIL;
                    banner_next = BANNER_LOAD;
                end else if (stagePassed && ((levelIndex == LAST_LEVEL) || lastLevelEnded)) begin
                    state_next  = S_WIN;
                    banner_next = BANNER_LOAD;
                end else if (stagePassed) begin
                    state_next  = S_PASS;
                    banner_next = BANNER_LOAD;
                end
            end
            S_PASS, S_FAIL, S_WIN: begin
                if (oneSecPulse) begin
                    if (banner_cnt == CNT_W'(1)) begin
                        banner_next = '0;
                        if (state == S_PASS) begin
                            // PASS is never entered on the last level, so no wrap.
                            level_next = (levelIndex == LAST_LEVEL) ? levelIndex
                                                                    : levelIndex + LEVEL_W'(1);
                            cycle_next = 1'b1;
                            state_next = S_ARM;
                        end else begin
                            state_next = S_TITLE;
                        end
                    end else begin
                        banner_next = banner_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next  = S_TITLE;
                banner_next = '0;
            end
        endcase
    end

    // Screen/enable decode of the upcoming state, registered so outputs track the state register.
    always_comb begin
        enable_next = 1'b0;
        screen_next = SCR_TITLE;
        over_next   = 1'b0;
        won_next    = 1'b0;
        case (state_next)
            S_TITLE: screen_next = SCR_TITLE;
            S_ARM:   screen_next = SCR_PLAY;
            S_PLAY: begin
                screen_next = SCR_PLAY;
                enable_next = 1'b1;
            end
            S_PASS:  screen_next = SCR_PASS;
            S_FAIL: begin
                screen_next = SCR_FAIL;
                over_next   = 1'b1;
            end
            S_WIN: begin
                screen_next = SCR_WIN;
                won_next    = 1'b1;
            end
            default: screen_next = SCR_TITLE;
        endcase
    end

    // State, counters and registered outputs; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state       <= S_TITLE;
            banner_cnt  <= '0;
            levelIndex  <= '0;
            cycleLevel  <= 1'b0;
            start_d     <= 1'b1;
            levelEnable <= 1'b0;
            screenSel   <= SCR_TITLE;
            gameOver    <= 1'b0;
            gameWon     <= 1'b0;
        end else begin
            state       <= state_next;
            banner_cnt  <= banner_next;
            levelIndex  <= level_next;
            cycleLevel  <= cycle_next;
            start_d     <= startKey;
            levelEnable <= enable_next;
            screenSel   <= screen_next;
            gameOver    <= over_next;
            gameWon     <= won_next;
        end
    end

endmodule
